// File: rtl/joypad_port.sv
// NES-style controller port for $4016/$4017: snapshots USB pad state, latches it
// on the strobe falling edge and serialises one button per CPU read.
module joypad_port #(
  parameter logic [2:0] OPEN_BUS_HI   = 3'b010,
  parameter bit         MASK_OPPOSING = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       addr,
  input  logic       rw,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] buttons0,
  input  logic [7:0] buttons1,
  input  logic       buttons_valid,
  output logic       strobe,
  output logic [3:0] read_count0,
  output logic [3:0] read_count1
);

  localparam logic [3:0] COUNT_MAX = 4'd8;

  logic [1:0][7:0] snap_q, snap_d;
  logic [1:0][7:0] shift_q, shift_d;
  logic [1:0][3:0] count_q, count_d;
  logic            strobe_q, strobe_d;
  logic            cs_n_q;

  logic rd_access, wr_access, rd_first;

  // Opposing directions cannot both be pressed on a real d-pad; games misbehave if they are.
  function automatic logic [7:0] mask_dirs(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (MASK_OPPOSING) begin
      if (b[4] && b[5]) r[5:4] = 2'b00;
      if (b[6] && b[7]) r[7:6] = 2'b00;
    end
    return r;
  endfunction

  assign rd_access = rst_n && !cs_n && rw;
  assign wr_access = !cs_n && !rw && !addr;
  assign rd_first  = rd_access && cs_n_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    snap_d   = snap_q;
    strobe_d = strobe_q;
    shift_d  = shift_q;
    count_d  = count_q;

    if (buttons_valid) begin
      snap_d[0] = mask_dirs(buttons0);
      snap_d[1] = mask_dirs(buttons1);
    end

    if (wr_access) strobe_d = data_in[0];

    // Reloading from snap_d covers both the held strobe and the falling edge,
    // and lets a same-edge valid pulse land in the latch.
    if (strobe_q) begin
      shift_d = snap_d;
      count_d = '0;
    end else if (rd_first) begin
      shift_d[addr] = {1'b1, shift_q[addr][7:1]};
      if (count_q[addr] != COUNT_MAX) count_d[addr] = count_q[addr] + 4'd1;
    end
  end

  always_comb begin
    data_oe  = 1'b0;
    data_out = 8'h00;
    if (rd_access) begin
      data_oe  = 1'b1;
      data_out = {OPEN_BUS_HI, 4'b0000,
                  strobe_q ? snap_q[addr][0] : shift_q[addr][0]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q   <= '0;
      shift_q  <= {8'hFF, 8'hFF};
      count_q  <= '0;
      strobe_q <= 1'b0;
      cs_n_q   <= 1'b0;
    end else begin
      snap_q   <= snap_d;
      shift_q  <= shift_d;
      count_q  <= count_d;
      strobe_q <= strobe_d;
      cs_n_q   <= cs_n;
    end
  end

  assign strobe      = strobe_q;
  assign read_count0 = count_q[0];
  assign read_count1 = count_q[1];

endmodule

// File: tb/tb_joypad_port.sv
// Self-checking bench for joypad_port: scoreboarded reads against a masked and
// an unmasked instance driven from the same CPU bus.
module tb_joypad_port;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       addr = 1'b0;
  logic       rw = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic [7:0] buttons0 = 8'h00;
  logic [7:0] buttons1 = 8'h00;
  logic       buttons_valid = 1'b0;

  logic [7:0] data_out, data_out_nm;
  logic       data_oe, data_oe_nm;
  logic       strobe, strobe_nm;
  logic [3:0] rc0, rc1, rc0_nm, rc1_nm;

  int n_checks = 0;
  int n_bad    = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_nm_q[$];

  joypad_port dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .addr(addr), .rw(rw),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .buttons0(buttons0), .buttons1(buttons1), .buttons_valid(buttons_valid),
    .strobe(strobe), .read_count0(rc0), .read_count1(rc1)
  );

  joypad_port #(.MASK_OPPOSING(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .addr(addr), .rw(rw),
    .data_in(data_in), .data_out(data_out_nm), .data_oe(data_oe_nm),
    .buttons0(buttons0), .buttons1(buttons1), .buttons_valid(buttons_valid),
    .strobe(strobe_nm), .read_count0(rc0_nm), .read_count1(rc1_nm)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_mask(input logic [7:0] b, input bit m);
    logic [7:0] r;
    r = b;
    if (m && b[4] && b[5]) r = r & 8'hCF;
    if (m && b[6] && b[7]) r = r & 8'h3F;
    return r;
  endfunction

  // Bit seen on the i-th read after a latch of pad value b.
  function automatic logic exp_bit(input logic [7:0] b, input bit m, input int i);
    logic [7:0] r;
    r = model_mask(b, m);
    if (i >= 8) return 1'b1;
    return r[i];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] b0, input logic [7:0] b1);
    buttons0 = b0;
    buttons1 = b1;
    buttons_valid = 1'b1;
    step();
    buttons_valid = 1'b0;
  endtask

  task automatic wr(input logic port, input logic [7:0] d);
    cs_n = 1'b0; rw = 1'b0; addr = port; data_in = d;
    step();
    cs_n = 1'b1; rw = 1'b1;
    step();
  endtask

  // One read access held low for `hold` cycles; expected values go through the scoreboard.
  task automatic do_read(input logic port, input logic b, input logic b_nm,
                         input string tag, input int hold = 1);
    logic [7:0] e, e_nm;
    cs_n = 1'b0; rw = 1'b1; addr = port;
    exp_q.push_back({3'b010, 4'b0000, b});
    exp_nm_q.push_back({3'b010, 4'b0000, b_nm});
    @(negedge clk);
    e    = exp_q.pop_front();
    e_nm = exp_nm_q.pop_front();
    n_checks++;
    if (data_out !== e || data_oe !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: data_out=%h oe=%b, want %h oe=1", tag, data_out, data_oe, e);
    end
    n_checks++;
    if (data_out_nm !== e_nm || data_oe_nm !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_nomask: data_out=%h oe=%b, want %h oe=1", tag, data_out_nm, data_oe_nm, e_nm);
    end
    repeat (hold) @(posedge clk);
    #1;
    cs_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    cs_n = 1'b0; rw = 1'b1; addr = 1'b0;
    #3;
    n_checks++;
    if (data_oe !== 1'b0 || data_out !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_bus: oe=%b data_out=%h, want oe=0 data_out=00", data_oe, data_out);
    end
    n_checks++;
    if (strobe !== 1'b0 || rc0 !== 4'd0 || rc1 !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_state: strobe=%b rc0=%0d rc1=%0d, want 0/0/0", strobe, rc0, rc1);
    end
    cs_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
  endtask

  task automatic test_latch_read();
    pulse(8'h09, 8'h00);
    wr(1'b0, 8'h01);
    n_checks++;
    if (strobe !== 1'b1) begin
      n_bad++;
      $display("FAIL strobe_set: strobe=%b, want 1", strobe);
    end
    wr(1'b0, 8'h00);
    n_checks++;
    if (strobe !== 1'b0) begin
      n_bad++;
      $display("FAIL strobe_clear: strobe=%b, want 0", strobe);
    end
    for (int i = 0; i < 10; i++) begin
      do_read(1'b0, exp_bit(8'h09, 1, i), exp_bit(8'h09, 0, i), "latch_read");
      n_checks++;
      if (rc0 !== ((i < 8) ? 4'(i + 1) : 4'd8)) begin
        n_bad++;
        $display("FAIL latch_count: read %0d rc0=%0d, want %0d", i, rc0, (i < 8) ? i + 1 : 8);
      end
    end
  endtask

  task automatic test_strobe_held();
    logic v;
    wr(1'b0, 8'h01);
    for (int k = 0; k < 4; k++) begin
      v = (k % 2 == 0);
      pulse({7'b0, v}, 8'h00);
      do_read(1'b0, v, v, "strobe_live");
      do_read(1'b0, v, v, "strobe_repeat");
      n_checks++;
      if (rc0 !== 4'd0) begin
        n_bad++;
        $display("FAIL strobe_count: rc0=%0d, want 0", rc0);
      end
    end
  endtask

  // Valid pulse and strobe falling edge on the same clock, then a mid-stream snapshot change.
  task automatic test_back_to_back();
    buttons0 = 8'hC2; buttons1 = 8'h00; buttons_valid = 1'b1;
    cs_n = 1'b0; rw = 1'b0; addr = 1'b0; data_in = 8'h00;
    step();
    buttons_valid = 1'b0; cs_n = 1'b1; rw = 1'b1;
    step();
    n_checks++;
    if (strobe !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_strobe: strobe=%b, want 0", strobe);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 2) pulse(8'hFF, 8'h00);
      do_read(1'b0, exp_bit(8'hC2, 1, i), exp_bit(8'hC2, 0, i), "b2b_read");
    end
  endtask

  task automatic test_masking();
    pulse(8'h00, 8'h30);
    wr(1'b0, 8'h01);
    wr(1'b0, 8'h00);
    for (int i = 0; i < 8; i++)
      do_read(1'b1, exp_bit(8'h30, 1, i), exp_bit(8'h30, 0, i), "mask_read");
    n_checks++;
    if (rc1 !== 4'd8 || rc0 !== 4'd0) begin
      n_bad++;
      $display("FAIL mask_counts: rc1=%0d rc0=%0d, want 8/0", rc1, rc0);
    end
  endtask

  task automatic test_held_access();
    pulse(8'h00, 8'h02);
    wr(1'b0, 8'h01);
    wr(1'b0, 8'h00);
    do_read(1'b1, 1'b0, 1'b0, "held_first", 3);
    n_checks++;
    if (rc1 !== 4'd1 || rc0 !== 4'd0) begin
      n_bad++;
      $display("FAIL held_counts: rc1=%0d rc0=%0d, want 1/0", rc1, rc0);
    end
    do_read(1'b1, 1'b1, 1'b1, "held_next");
    n_checks++;
    if (rc1 !== 4'd2) begin
      n_bad++;
      $display("FAIL held_count2: rc1=%0d, want 2", rc1);
    end
    wr(1'b1, 8'h01);
    n_checks++;
    if (strobe !== 1'b0) begin
      n_bad++;
      $display("FAIL apu_write: strobe=%b, want 0", strobe);
    end
  endtask

  task automatic test_async_reset();
    pulse(8'h08, 8'h00);
    wr(1'b0, 8'h01);
    wr(1'b0, 8'h00);
    for (int i = 0; i < 3; i++)
      do_read(1'b0, exp_bit(8'h08, 1, i), exp_bit(8'h08, 0, i), "pre_reset");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    cs_n = 1'b0; rw = 1'b1; addr = 1'b0;
    #1;
    n_checks++;
    if (data_oe !== 1'b0 || data_out !== 8'h00 || strobe !== 1'b0 || rc0 !== 4'd0) begin
      n_bad++;
      $display("FAIL async_reset: oe=%b data_out=%h strobe=%b rc0=%0d, want 0/00/0/0",
               data_oe, data_out, strobe, rc0);
    end
    cs_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    do_read(1'b0, 1'b1, 1'b1, "post_reset");
    n_checks++;
    if (rc0 !== 4'd1) begin
      n_bad++;
      $display("FAIL post_reset_count: rc0=%0d, want 1", rc0);
    end
  endtask

  initial begin
    test_reset();
    test_latch_read();
    test_strobe_held();
    test_back_to_back();
    test_masking();
    test_held_access();
    test_async_reset();
    n_checks++;
    if (exp_q.size() != 0 || exp_nm_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, want 0", exp_q.size(), exp_nm_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
